// File: rtl/tcp_slow_state_pkg.sv
// Shared types and defaults for the TCP slow-path flow-state datapath
// (state mux, write queue, state RAM).
package tcp_slow_state_pkg;

  localparam int FLOWID_W = 8;
  localparam int STATE_W  = 64;

  // One flow-state write request as carried between mux, queue and RAM.
  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic [STATE_W-1:0]  state;
  } state_wr_req_t;

  // Queue pointers carry one extra wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/state_wr_queue_mem.sv
// Register file backing the state write queue: one write port, an async
// head read port and an async tail flow-id read port for coalescing.
// Contents are deliberately not reset; validity lives in the pointers.
module state_wr_queue_mem
  import tcp_slow_state_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int FLOWID_W = tcp_slow_state_pkg::FLOWID_W,
  parameter int STATE_W  = tcp_slow_state_pkg::STATE_W,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [FLOWID_W-1:0] wflowid_i,
  input  logic [STATE_W-1:0]  wstate_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [FLOWID_W-1:0] rflowid_o,
  output logic [STATE_W-1:0]  rstate_o,
  input  logic [AW-1:0]       taddr_i,
  output logic [FLOWID_W-1:0] tflowid_o
);

  logic [FLOWID_W-1:0] flowid_q [DEPTH];
  logic [STATE_W-1:0]  state_q  [DEPTH];

  // Write port: store a new entry or overwrite the tail in place.
  always_ff @(posedge clk) begin
    if (we_i) begin
      flowid_q[waddr_i] <= wflowid_i;
      state_q[waddr_i]  <= wstate_i;
    end
  end

  assign rflowid_o = flowid_q[raddr_i];
  assign rstate_o  = state_q[raddr_i];
  assign tflowid_o = flowid_q[taddr_i];

endmodule

// File: rtl/state_wr_queue.sv
// Elastic FWFT write queue in front of the flow-state memory write port.
// Optional feature: define STATE_WR_QUEUE_COALESCE_EN to merge a write into
// the tail entry when it targets the same flow (adds coalesce_cnt output).
module state_wr_queue
  import tcp_slow_state_pkg::*;
#(
  parameter int FLOWID_W = tcp_slow_state_pkg::FLOWID_W,
  parameter int STATE_W  = tcp_slow_state_pkg::STATE_W,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 32,
  localparam int AW      = $clog2(DEPTH),
  localparam int PTR_W   = ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_wr_val,
  input  logic [FLOWID_W-1:0] in_wr_flowid,
  input  logic [STATE_W-1:0]  in_wr_state,
  output logic                in_wr_rdy,
  output logic                mem_wr_val,
  output logic [FLOWID_W-1:0] mem_wr_addr,
  output logic [STATE_W-1:0]  mem_wr_data,
  input  logic                mem_wr_rdy,
  output logic [PTR_W-1:0]    occupancy,
  output logic [CNT_W-1:0]    wr_cnt
`ifdef STATE_WR_QUEUE_COALESCE_EN
  ,
  output logic [CNT_W-1:0]    coalesce_cnt
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [AW-1:0]    IDX_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                full_s, empty_s, pop_s, acc_s, push_s, hit_s;
  logic [AW-1:0]       tail_idx_s, waddr_s;
  logic [FLOWID_W-1:0] tail_flowid_s;

  assign full_s     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign pop_s      = ~empty_s & mem_wr_rdy;
  assign tail_idx_s = wr_ptr_q[AW-1:0] - IDX_ONE;

`ifdef STATE_WR_QUEUE_COALESCE_EN
  logic [CNT_W-1:0] coal_cnt_q, coal_cnt_d;

  // Never merge into the sole entry while it is leaving this cycle.
  assign hit_s = in_wr_val & (occ_q != {PTR_W{1'b0}}) &
                 (tail_flowid_s == in_wr_flowid) &
                 ~((occ_q == PTR_ONE) & pop_s);

  // Coalesce counter next state.
  always_comb begin
    coal_cnt_d = coal_cnt_q;
    if (hit_s) begin
      coal_cnt_d = coal_cnt_q + CNT_ONE;
    end else begin
      coal_cnt_d = coal_cnt_q;
    end
  end

  // Coalesce counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coal_cnt_q <= {CNT_W{1'b0}};
    end else begin
      coal_cnt_q <= coal_cnt_d;
    end
  end

  assign coalesce_cnt = coal_cnt_q;
`else
  logic unused_tail_s;

  assign hit_s         = 1'b0;
  assign unused_tail_s = ^tail_flowid_s;
`endif

  // A slot freed by a same-cycle pop is not reused until the next cycle.
  assign in_wr_rdy = ~rst & (~full_s | hit_s);
  assign acc_s     = in_wr_val & in_wr_rdy;
  assign push_s    = acc_s & ~hit_s;
  assign waddr_s   = hit_s ? tail_idx_s : wr_ptr_q[AW-1:0];

  state_wr_queue_mem #(
    .DEPTH    (DEPTH),
    .FLOWID_W (FLOWID_W),
    .STATE_W  (STATE_W)
  ) u_mem (
    .clk       (clk),
    .we_i      (acc_s),
    .waddr_i   (waddr_s),
    .wflowid_i (in_wr_flowid),
    .wstate_i  (in_wr_state),
    .raddr_i   (rd_ptr_q[AW-1:0]),
    .rflowid_o (mem_wr_addr),
    .rstate_o  (mem_wr_data),
    .taddr_i   (tail_idx_s),
    .tflowid_o (tail_flowid_s)
  );

  // Pointer, occupancy and write-counter next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    wr_cnt_d = wr_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      wr_cnt_d = wr_cnt_q + CNT_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
      wr_cnt_d = wr_cnt_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + PTR_ONE;
      2'b01:   occ_d = occ_q - PTR_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Queue control registers; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {PTR_W{1'b0}};
      wr_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign mem_wr_val = ~empty_s;
  assign occupancy  = occ_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_state_wr_queue.sv
// Directed self-checking bench for state_wr_queue (DEPTH=4 defaults).
// Follows STATE_WR_QUEUE_COALESCE_EN if it is defined for the build.
module tb_state_wr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_wr_val;
  logic [7:0]  in_wr_flowid;
  logic [63:0] in_wr_state;
  logic        in_wr_rdy;
  logic        mem_wr_val;
  logic [7:0]  mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_rdy;
  logic [2:0]  occupancy;
  logic [31:0] wr_cnt;
`ifdef STATE_WR_QUEUE_COALESCE_EN
  logic [31:0] coalesce_cnt;
`endif

  int checks = 0;
  int errors = 0;

  state_wr_queue dut (
    .clk          (clk),
    .rst          (rst),
    .in_wr_val    (in_wr_val),
    .in_wr_flowid (in_wr_flowid),
    .in_wr_state  (in_wr_state),
    .in_wr_rdy    (in_wr_rdy),
    .mem_wr_val   (mem_wr_val),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_rdy   (mem_wr_rdy),
    .occupancy    (occupancy),
    .wr_cnt       (wr_cnt)
`ifdef STATE_WR_QUEUE_COALESCE_EN
    ,
    .coalesce_cnt (coalesce_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_wr_val    = 1'b0;
    in_wr_flowid = 8'h00;
    in_wr_state  = 64'h0;
    mem_wr_rdy   = 1'b0;
    tick();
    tick();
    check("rst_rdy", {63'h0, in_wr_rdy}, 64'h0);
    check("rst_val", {63'h0, mem_wr_val}, 64'h0);
    check("rst_occ", {61'h0, occupancy}, 64'h0);
    check("rst_cnt", {32'h0, wr_cnt}, 64'h0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {63'h0, in_wr_rdy}, 64'h1);

    // Single write through an always-ready memory.
    mem_wr_rdy   = 1'b1;
    in_wr_val    = 1'b1;
    in_wr_flowid = 8'h03;
    in_wr_state  = 64'hAA;
    tick();
    in_wr_val = 1'b0;
    check("single_val", {63'h0, mem_wr_val}, 64'h1);
    check("single_addr", {56'h0, mem_wr_addr}, 64'h3);
    check("single_data", mem_wr_data, 64'hAA);
    check("single_occ1", {61'h0, occupancy}, 64'h1);
    tick();
    check("single_cnt", {32'h0, wr_cnt}, 64'h1);
    check("single_occ0", {61'h0, occupancy}, 64'h0);
    check("single_empty", {63'h0, mem_wr_val}, 64'h0);

    // Fill to DEPTH while memory stalls, then a fifth request must hold.
    mem_wr_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_wr_val    = 1'b1;
      in_wr_flowid = 8'(i);
      in_wr_state  = 64'h10 + 64'(i);
      tick();
    end
    in_wr_flowid = 8'h05;
    in_wr_state  = 64'h15;
    check("full_occ", {61'h0, occupancy}, 64'h4);
    check("full_rdy", {63'h0, in_wr_rdy}, 64'h0);
    tick();
    tick();
    check("full_hold_occ", {61'h0, occupancy}, 64'h4);
    check("full_hold_head", {56'h0, mem_wr_addr}, 64'h1);
    mem_wr_rdy = 1'b1;
    check("full_rdy_pop", {63'h0, in_wr_rdy}, 64'h0);
    for (int k = 0; k < 5; k++) begin
      check("drain_val", {63'h0, mem_wr_val}, 64'h1);
      check("drain_addr", {56'h0, mem_wr_addr}, 64'(k + 1));
      check("drain_data", mem_wr_data, 64'h11 + 64'(k));
      tick();
      if (k == 1) in_wr_val = 1'b0;
    end
    check("drain_occ", {61'h0, occupancy}, 64'h0);
    check("drain_cnt", {32'h0, wr_cnt}, 64'd6);

    // Streaming: push and pop every cycle.
    for (int i = 0; i < 100; i++) begin
      in_wr_val    = 1'b1;
      in_wr_flowid = 8'(i);
      in_wr_state  = 64'(i) + 64'h1000;
      tick();
      check("stream_occ", {61'h0, occupancy}, 64'h1);
      check("stream_head", {mem_wr_val, 55'h0, mem_wr_addr}, {1'b1, 55'h0, 8'(i)});
    end
    in_wr_val = 1'b0;
    tick();
    check("stream_occ_end", {61'h0, occupancy}, 64'h0);
    check("stream_cnt", {32'h0, wr_cnt}, 64'd106);

    // Asynchronous reset with three entries queued.
    mem_wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_wr_val    = 1'b1;
      in_wr_flowid = 8'h21 + 8'(i);
      in_wr_state  = 64'h21 + 64'(i);
      tick();
    end
    in_wr_val = 1'b0;
    check("pre_rst_occ", {61'h0, occupancy}, 64'h3);
    rst = 1'b1;
    #1;
    check("async_rst_val", {63'h0, mem_wr_val}, 64'h0);
    check("async_rst_occ", {61'h0, occupancy}, 64'h0);
    check("async_rst_cnt", {32'h0, wr_cnt}, 64'h0);
    tick();
    rst        = 1'b0;
    mem_wr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_val", {63'h0, mem_wr_val}, 64'h0);
    end
    check("no_stale_cnt", {32'h0, wr_cnt}, 64'h0);

    // Back-to-back writes to the same flow while memory stalls.
    mem_wr_rdy   = 1'b0;
    in_wr_val    = 1'b1;
    in_wr_flowid = 8'h07;
    in_wr_state  = 64'h1;
    tick();
    in_wr_state  = 64'h2;
    tick();
    in_wr_val = 1'b0;
`ifdef STATE_WR_QUEUE_COALESCE_EN
    check("coal_occ", {61'h0, occupancy}, 64'h1);
    check("coal_data", mem_wr_data, 64'h2);
    check("coal_cnt", {32'h0, coalesce_cnt}, 64'h1);
    mem_wr_rdy = 1'b1;
    tick();
    check("coal_wr_cnt", {32'h0, wr_cnt}, 64'h1);
`else
    check("nocoal_occ", {61'h0, occupancy}, 64'h2);
    check("nocoal_data1", mem_wr_data, 64'h1);
    mem_wr_rdy = 1'b1;
    tick();
    check("nocoal_data2", mem_wr_data, 64'h2);
    tick();
    check("nocoal_wr_cnt", {32'h0, wr_cnt}, 64'h2);
`endif
    check("coal_drained", {61'h0, occupancy}, 64'h0);

    // Same-flow push while the single entry pops: queued, not merged.
    mem_wr_rdy   = 1'b0;
    in_wr_val    = 1'b1;
    in_wr_flowid = 8'h09;
    in_wr_state  = 64'h5;
    tick();
    mem_wr_rdy  = 1'b1;
    in_wr_state = 64'h6;
    tick();
    in_wr_val  = 1'b0;
    mem_wr_rdy = 1'b0;
    check("pop_push_occ", {61'h0, occupancy}, 64'h1);
    check("pop_push_addr", {56'h0, mem_wr_addr}, 64'h9);
    check("pop_push_data", mem_wr_data, 64'h6);
`ifdef STATE_WR_QUEUE_COALESCE_EN
    check("pop_push_coal", {32'h0, coalesce_cnt}, 64'h1);
`endif
    mem_wr_rdy = 1'b1;
    tick();
`ifdef STATE_WR_QUEUE_COALESCE_EN
    check("pop_push_cnt", {32'h0, wr_cnt}, 64'h3);

    // Matching write is accepted even while full.
    mem_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_wr_val    = 1'b1;
      in_wr_flowid = 8'h30 + 8'(i);
      in_wr_state  = 64'h30 + 64'(i);
      tick();
    end
    in_wr_state = 64'hBEEF;
    check("full_hit_rdy", {63'h0, in_wr_rdy}, 64'h1);
    tick();
    in_wr_val = 1'b0;
    check("full_hit_occ", {61'h0, occupancy}, 64'h4);
    check("full_hit_coal", {32'h0, coalesce_cnt}, 64'h2);
    mem_wr_rdy = 1'b1;
    tick();
    tick();
    tick();
    check("full_hit_tail", mem_wr_data, 64'hBEEF);
    tick();
    check("full_hit_cnt", {32'h0, wr_cnt}, 64'h7);
`else
    check("pop_push_cnt", {32'h0, wr_cnt}, 64'h4);
`endif
    check("final_occ", {61'h0, occupancy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
